// File: rtl/mips_regfile.sv
// Register bank with two combinational read ports, one write port and a per-register pending-write scoreboard.
// Latency: reads zero-cycle; writes and reservations take effect at the next i_clk rise. REGFILE_BYPASS_EN forwards same-cycle write data to reads.
// Backpressure: none; every write and reservation is accepted on the edge it is presented.
module mips_regfile #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_rd_addr_a,
    output logic [DATA_W-1:0] o_rd_data_a,
    output logic              o_busy_a,
    input  logic [ADDR_W-1:0] i_rd_addr_b,
    output logic [DATA_W-1:0] o_rd_data_b,
    output logic              o_busy_b,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_resv_en,
    input  logic [ADDR_W-1:0] i_resv_addr
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // One-hot decodes; the hardwired zero register never sees a hit.
    logic [NUM_REGS-1:0] wr_dec;
    logic [NUM_REGS-1:0] resv_dec;

    always_comb begin
        wr_dec   = '0;
        resv_dec = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            wr_dec[r]   = i_wr_en   && (i_wr_addr   == ADDR_W'(r));
            resv_dec[r] = i_resv_en && (i_resv_addr == ADDR_W'(r));
        end
        if (ZERO_REG != 0) begin
            wr_dec[0]   = 1'b0;
            resv_dec[0] = 1'b0;
        end
    end

    // A new producer reserving on the same edge an old one retires keeps the register busy.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (wr_dec[r]) begin
                regs_d[r] = i_wr_data;
            end
            if (resv_dec[r]) begin
                busy_d[r] = 1'b1;
            end else if (wr_dec[r]) begin
                busy_d[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q <= busy_d;
        end
    end

    logic fwd_a;
    logic fwd_b;

    always_comb begin
        fwd_a = 1'b0;
        fwd_b = 1'b0;
`ifdef REGFILE_BYPASS_EN
        // Gated by reset so the outputs read zero for as long as reset is held.
        fwd_a = i_rst_n && wr_dec[i_rd_addr_a];
        fwd_b = i_rst_n && wr_dec[i_rd_addr_b];
`endif
    end

    always_comb begin
        o_rd_data_a = fwd_a ? i_wr_data : regs_q[i_rd_addr_a];
        o_rd_data_b = fwd_b ? i_wr_data : regs_q[i_rd_addr_b];
        if ((ZERO_REG != 0) && (i_rd_addr_a == '0)) begin
            o_rd_data_a = '0;
        end
        if ((ZERO_REG != 0) && (i_rd_addr_b == '0)) begin
            o_rd_data_b = '0;
        end
    end

    // Busy comes from registered state only; a write retiring this cycle clears it next cycle.
    assign o_busy_a = busy_q[i_rd_addr_a];
    assign o_busy_b = busy_q[i_rd_addr_b];

endmodule

// File: tb/tb_mips_regfile.sv
// Scoreboard bench for mips_regfile: stimulus queues expected read-port values, a monitor pops and compares them.
module tb_mips_regfile;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rd_addr_a;
    logic [31:0] rd_data_a;
    logic        busy_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_b;
    logic        busy_b;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        resv_en;
    logic [4:0]  resv_addr;

    mips_regfile #(
        .DATA_W   (32),
        .NUM_REGS (32),
        .ADDR_W   (5),
        .ZERO_REG (1)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rd_addr_a (rd_addr_a),
        .o_rd_data_a (rd_data_a),
        .o_busy_a    (busy_a),
        .i_rd_addr_b (rd_addr_b),
        .o_rd_data_b (rd_data_b),
        .o_busy_b    (busy_b),
        .i_wr_en     (wr_en),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .i_resv_en   (resv_en),
        .i_resv_addr (resv_addr)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct packed {
        logic [31:0] da;
        logic        ba;
        logic [31:0] db;
        logic        bb;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    event  smp_ev;
    int    checks = 0;
    int    errors = 0;

    // Monitor: each sample strobe consumes one queued expectation.
    initial begin
        forever begin
            @(smp_ev);
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sample-without-expectation");
            end else begin
                exp_t  e;
                string n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checks++;
                if (rd_data_a !== e.da || busy_a !== e.ba || rd_data_b !== e.db || busy_b !== e.bb) begin
                    errors++;
                    $display("FAIL %s: got a=%h/%b b=%h/%b, want a=%h/%b b=%h/%b",
                             n, rd_data_a, busy_a, rd_data_b, busy_b, e.da, e.ba, e.db, e.bb);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic set_rd(input logic [4:0] a, input logic [4:0] b);
        rd_addr_a = a;
        rd_addr_b = b;
        #1;
    endtask

    task automatic expect_rd(input string n, input logic [31:0] da, input logic ba,
                             input logic [31:0] db, input logic bb);
        exp_t e;
        e.da = da; e.ba = ba; e.db = db; e.bb = bb;
        exp_q.push_back(e);
        name_q.push_back(n);
        ->smp_ev;
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick;
        wr_en = 1'b0;
    endtask

    task automatic do_resv(input logic [4:0] a);
        resv_en = 1'b1; resv_addr = a;
        tick;
        resv_en = 1'b0;
    endtask

    logic [31:0] exp_byp;

    initial begin
        rst_n = 1'b1;
        rd_addr_a = '0; rd_addr_b = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        resv_en = 1'b0; resv_addr = '0;
        #1 rst_n = 1'b0;
        #2;
        set_rd(5'd0, 5'd5);
        expect_rd("reset_initial", 32'h0, 1'b0, 32'h0, 1'b0);
        tick;
        rst_n = 1'b1;
        tick;

        // Random writes and a reservation, then reset between edges.
        do_write(5'd1, 32'h0BAD_F00D);
        do_write(5'd2, 32'h1357_9BDF);
        do_write(5'd31, 32'hFFFF_0001);
        do_resv(5'd4);
        set_rd(5'd1, 5'd4);
        expect_rd("pre_reset", 32'h0BAD_F00D, 1'b0, 32'h0, 1'b1);
        rst_n = 1'b0;
        #1;
        set_rd(5'd2, 5'd31);
        expect_rd("reset_held", 32'h0, 1'b0, 32'h0, 1'b0);
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            set_rd(5'(i), 5'(i + 16));
            expect_rd($sformatf("post_reset_sweep_%0d", i), 32'h0, 1'b0, 32'h0, 1'b0);
        end
        tick;

        // Basic write/read and hardwired zero.
        do_write(5'd5, 32'hDEAD_BEEF);
        set_rd(5'd5, 5'd5);
        expect_rd("write_read_5", 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0);
        do_write(5'd0, 32'h0000_1234);
        set_rd(5'd0, 5'd0);
        expect_rd("zero_reg_write", 32'h0, 1'b0, 32'h0, 1'b0);

        // Same-cycle write visibility.
        do_write(5'd7, 32'h1111_1111);
`ifdef REGFILE_BYPASS_EN
        exp_byp = 32'hA5A5_A5A5;
`else
        exp_byp = 32'h1111_1111;
`endif
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5_A5A5;
        set_rd(5'd7, 5'd5);
        expect_rd("same_cycle_write", exp_byp, 1'b0, 32'hDEAD_BEEF, 1'b0);
        tick;
        wr_en = 1'b0;
        set_rd(5'd7, 5'd7);
        expect_rd("after_write_7", 32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5, 1'b0);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
        set_rd(5'd0, 5'd7);
        expect_rd("zero_no_forward", 32'h0, 1'b0, 32'hA5A5_A5A5, 1'b0);
        tick;
        wr_en = 1'b0;

        // Reserve then retire.
        do_resv(5'd9);
        set_rd(5'd9, 5'd7);
        expect_rd("resv_9_busy", 32'h0, 1'b1, 32'hA5A5_A5A5, 1'b0);
`ifdef REGFILE_BYPASS_EN
        exp_byp = 32'h0000_0042;
`else
        exp_byp = 32'h0;
`endif
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_0042;
        set_rd(5'd9, 5'd9);
        expect_rd("write_9_busy_holds", exp_byp, 1'b1, exp_byp, 1'b1);
        tick;
        wr_en = 1'b0;
        set_rd(5'd9, 5'd9);
        expect_rd("write_9_cleared", 32'h0000_0042, 1'b0, 32'h0000_0042, 1'b0);

        // Re-reserve keeps busy; one write clears.
        do_resv(5'd10);
        do_resv(5'd10);
        set_rd(5'd10, 5'd9);
        expect_rd("rereserve_10", 32'h0, 1'b1, 32'h0000_0042, 1'b0);
        do_write(5'd10, 32'h0000_0077);
        set_rd(5'd10, 5'd10);
        expect_rd("rereserve_10_cleared", 32'h0000_0077, 1'b0, 32'h0000_0077, 1'b0);

        // Reserve and write to different registers on one edge.
        resv_en = 1'b1; resv_addr = 5'd11;
        wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h0000_0055;
        tick;
        resv_en = 1'b0; wr_en = 1'b0;
        set_rd(5'd11, 5'd12);
        expect_rd("resv11_write12", 32'h0, 1'b1, 32'h0000_0055, 1'b0);

        // Reserve and write to the same register: reserve wins, data updates.
        resv_en = 1'b1; resv_addr = 5'd3;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0099;
        tick;
        resv_en = 1'b0; wr_en = 1'b0;
        set_rd(5'd3, 5'd3);
        expect_rd("resv_write_same_3", 32'h0000_0099, 1'b1, 32'h0000_0099, 1'b1);
        do_resv(5'd0);
        set_rd(5'd0, 5'd3);
        expect_rd("resv_zero_ignored", 32'h0, 1'b0, 32'h0000_0099, 1'b1);

        // Async reset mid-cycle with reg12 busy and a write pending.
        do_resv(5'd12);
        set_rd(5'd12, 5'd3);
        expect_rd("resv_12_busy", 32'h0000_0055, 1'b1, 32'h0000_0099, 1'b1);
        tick;
        wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h0000_CAFE;
        set_rd(5'd12, 5'd3);
        rst_n = 1'b0;
        #1;
        expect_rd("async_reset_mid", 32'h0, 1'b0, 32'h0, 1'b0);
        tick;
        wr_en = 1'b0;
        rst_n = 1'b1;
        #1;
        set_rd(5'd12, 5'd12);
        expect_rd("pending_write_dropped", 32'h0, 1'b0, 32'h0, 1'b0);
        tick;
        set_rd(5'd12, 5'd5);
        expect_rd("state_after_release", 32'h0, 1'b0, 32'h0, 1'b0);

        #5;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
